// File: rtl/iserdes_sdr_deser.sv
`default_nettype none
// ============================================================================
// Module      : iserdes_sdr_deser
// Description : Single-clock SDR input deserializer with word-valid strobe
//               and bitslip engine with hold-off for word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module iserdes_sdr_deser #(
  parameter int   DATA_WIDTH      = 8,
  parameter logic INIT            = 1'b0,
  parameter logic IS_CLK_INVERTED = 1'b0,
  parameter logic IS_D_INVERTED   = 1'b0,
  parameter int   BITSLIP_HOLDOFF = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       D,
  input  logic       BITSLIP,
  output logic [7:0] Q,
  output logic       Q_VALID,
  output logic       BITSLIP_BUSY
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int HW = 7;
  localparam logic [CW-1:0] c_CNT_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
  localparam logic [HW-1:0] c_HOLD_LOAD = HW'(BITSLIP_HOLDOFF * DATA_WIDTH - 1);
  localparam logic [HW-1:0] c_HCNT_ONE  = HW'(1);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  if (!(DATA_WIDTH == 2 || DATA_WIDTH == 4 || DATA_WIDTH == 8)) begin : g_bad_width
    $error("iserdes_sdr_deser: DATA_WIDTH must be 2, 4 or 8");
  end
  if (BITSLIP_HOLDOFF < 1 || BITSLIP_HOLDOFF > 15) begin : g_bad_holdoff
    $error("iserdes_sdr_deser: BITSLIP_HOLDOFF must be 1..15");
  end

  logic                  w_clk;
  logic                  w_d;
  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_slip;
  logic                  w_last;

  // Only W-1 history bits are kept; the newest bit completes the word directly.
  logic [DATA_WIDTH-2:0] r_sr;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_valid;
  logic                  r_busy;
  logic [HW-1:0]         r_hcnt;
  state_t                r_state;

  assign w_clk   = CLK ^ IS_CLK_INVERTED;
  assign w_d     = D ^ IS_D_INVERTED;
  assign w_shift = {w_d, r_sr};
  assign w_slip  = (r_state == S_RUN) && BITSLIP;
  assign w_last  = (r_cnt == c_CNT_LAST);

  always_ff @(posedge w_clk) begin
    if (!RST) begin
      r_sr    <= {(DATA_WIDTH-1){INIT}};
      r_cnt   <= '0;
      r_q     <= {DATA_WIDTH{INIT}};
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_hcnt  <= '0;
      r_state <= S_RUN;
    end else begin
      r_valid <= 1'b0;
      if (CE) begin
        r_sr <= w_shift[DATA_WIDTH-1:1];
        // A taken slip freezes the counter, pushing the boundary one bit later.
        if (!w_slip) begin
          r_cnt <= w_last ? '0 : r_cnt + c_CNT_ONE;
          if (w_last) begin
            r_q     <= w_shift;
            r_valid <= 1'b1;
          end
        end
        case (r_state)
          S_RUN: begin
            if (BITSLIP) begin
              r_state <= S_HOLD;
              r_hcnt  <= c_HOLD_LOAD;
              r_busy  <= 1'b1;
            end
          end
          S_HOLD: begin
            if (r_hcnt == '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b0;
            end else begin
              r_hcnt <= r_hcnt - c_HCNT_ONE;
            end
          end
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

  if (DATA_WIDTH < 8) begin : g_pad
    assign Q = {{(8-DATA_WIDTH){1'b0}}, r_q};
  end else begin : g_full
    assign Q = r_q;
  end

  assign Q_VALID      = r_valid;
  assign BITSLIP_BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_iserdes_sdr_deser.sv
`default_nettype none
// Directed testbench for iserdes_sdr_deser; several parameter variants share one stimulus bus.
module tb_iserdes_sdr_deser;

  logic clk = 1'b0;
  logic rst, ce, d, bitslip;
  logic [7:0] q8, q4, qi, qd, qc;
  logic v8, v4, vi, vd, vc;
  logic b8, b4, bi, bd, bc;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  iserdes_sdr_deser #(.DATA_WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q(q8), .Q_VALID(v8), .BITSLIP_BUSY(b8));
  iserdes_sdr_deser #(.DATA_WIDTH(4)) u4 (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q(q4), .Q_VALID(v4), .BITSLIP_BUSY(b4));
  iserdes_sdr_deser #(.DATA_WIDTH(8), .INIT(1'b1)) ui (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q(qi), .Q_VALID(vi), .BITSLIP_BUSY(bi));
  iserdes_sdr_deser #(.DATA_WIDTH(8), .IS_D_INVERTED(1'b1)) ud (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q(qd), .Q_VALID(vd), .BITSLIP_BUSY(bd));
  iserdes_sdr_deser #(.DATA_WIDTH(8), .IS_CLK_INVERTED(1'b1)) uc (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q(qc), .Q_VALID(vc), .BITSLIP_BUSY(bc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic c, input logic s);
    d = b; ce = c; bitslip = s;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; ce = 1'b1; d = 1'b0; bitslip = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b0; d = 1'b1; bitslip = 1'b1;
    tick();
    tick();
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL reset_q8 got %h expected 00", q8); end
    tests_run++; if (v8 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b expected 0", v8); end
    tests_run++; if ({b8, b4, bi, bd, bc} !== 5'b0) begin tests_failed++; $display("FAIL reset_busy got %b expected 00000", {b8, b4, bi, bd, bc}); end
    tests_run++; if (qi !== 8'hFF) begin tests_failed++; $display("FAIL reset_init1 got %h expected ff", qi); end
    tests_run++; if (q4 !== 8'h00) begin tests_failed++; $display("FAIL reset_q4 got %h expected 00", q4); end
    tests_run++; if (qc !== 8'h00) begin tests_failed++; $display("FAIL reset_clkinv got %h expected 00", qc); end
    rst = 1'b1;
  endtask

  task automatic test_basic_w8();
    logic [7:0] w = 8'hA5;
    logic ev;
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      send(w[(i-1)%8], 1'b1, 1'b0);
      ev = (i % 8 == 0);
      tests_run++; if (v8 !== ev) begin tests_failed++; $display("FAIL basic_valid edge %0d got %b expected %b", i, v8, ev); end
      if (ev) begin
        tests_run++; if (q8 !== 8'hA5) begin tests_failed++; $display("FAIL basic_q edge %0d got %h expected a5", i, q8); end
      end
    end
  endtask

  task automatic test_w4();
    logic [11:0] s = 12'hC21;
    logic [7:0] exp4 [3] = '{8'h01, 8'h02, 8'h0C};
    logic ev;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send(s[i-1], 1'b1, 1'b0);
      ev = (i % 4 == 0);
      tests_run++; if (v4 !== ev) begin tests_failed++; $display("FAIL w4_valid edge %0d got %b expected %b", i, v4, ev); end
      if (ev) begin
        tests_run++; if (q4 !== exp4[i/4-1]) begin tests_failed++; $display("FAIL w4_q edge %0d got %h expected %h", i, q4, exp4[i/4-1]); end
      end
    end
  endtask

  task automatic test_bitslip();
    logic [7:0] w = 8'hA5;
    logic ev, eb;
    logic [7:0] eq;
    do_reset();
    for (int i = 1; i <= 42; i++) begin
      send(w[(i-1)%8], 1'b1, (i == 19 || i == 24));
      ev = (i == 8 || i == 16 || (i >= 25 && (i - 25) % 8 == 0));
      eq = (i <= 16) ? 8'hA5 : 8'hD2;
      eb = (i >= 19 && i <= 34);
      tests_run++; if (v8 !== ev) begin tests_failed++; $display("FAIL slip_valid edge %0d got %b expected %b", i, v8, ev); end
      if (ev) begin
        tests_run++; if (q8 !== eq) begin tests_failed++; $display("FAIL slip_q edge %0d got %h expected %h", i, q8, eq); end
      end
      tests_run++; if (b8 !== eb) begin tests_failed++; $display("FAIL slip_busy edge %0d got %b expected %b", i, b8, eb); end
    end
  endtask

  task automatic test_slip_at_boundary();
    logic [7:0] w = 8'hA5;
    logic ev;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      send(w[(i-1)%8], 1'b1, (i == 8));
      ev = (i == 9 || i == 17);
      tests_run++; if (v8 !== ev) begin tests_failed++; $display("FAIL bslip_valid edge %0d got %b expected %b", i, v8, ev); end
      if (ev) begin
        tests_run++; if (q8 !== 8'hD2) begin tests_failed++; $display("FAIL bslip_q edge %0d got %h expected d2", i, q8); end
      end
    end
  endtask

  task automatic test_ce_gating();
    logic [7:0] w1 = 8'h3C;
    logic [7:0] w2 = 8'hA5;
    logic ev;
    logic [7:0] eq;
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      if (i <= 8)       send(w1[i-1], 1'b1, 1'b0);
      else if (i <= 12) send(w2[i-9], 1'b1, 1'b0);
      else if (i <= 15) send(~w2[4], 1'b0, 1'b1);
      else              send(w2[i-12], 1'b1, 1'b0);
      ev = (i == 8 || i == 19);
      eq = (i == 19) ? 8'hA5 : 8'h3C;
      tests_run++; if (v8 !== ev) begin tests_failed++; $display("FAIL ce_valid edge %0d got %b expected %b", i, v8, ev); end
      if (i >= 8) begin
        tests_run++; if (q8 !== eq) begin tests_failed++; $display("FAIL ce_q edge %0d got %h expected %h", i, q8, eq); end
      end
      tests_run++; if (b8 !== 1'b0) begin tests_failed++; $display("FAIL ce_busy edge %0d got %b expected 0", i, b8); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w1 = 8'hA5;
    logic [7:0] w2 = 8'h3C;
    logic [7:0] w3 = 8'h96;
    logic ev;
    do_reset();
    for (int i = 1; i <= 8; i++) send(w1[i-1], 1'b1, 1'b0);
    tests_run++; if (vi !== 1'b1 || qi !== 8'hA5) begin tests_failed++; $display("FAIL rmid_first got %b/%h expected 1/a5", vi, qi); end
    for (int i = 9; i <= 13; i++) send(w2[i-9], 1'b1, 1'b0);
    rst = 1'b0;
    send(w2[5], 1'b1, 1'b0);
    tests_run++; if (qi !== 8'hFF) begin tests_failed++; $display("FAIL rmid_init got %h expected ff", qi); end
    tests_run++; if (vi !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid got %b expected 0", vi); end
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL rmid_init0 got %h expected 00", q8); end
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(w3[i-1], 1'b1, 1'b0);
      ev = (i == 8);
      tests_run++; if (vi !== ev) begin tests_failed++; $display("FAIL rmid_realign edge %0d got %b expected %b", i, vi, ev); end
    end
    tests_run++; if (qi !== 8'h96) begin tests_failed++; $display("FAIL rmid_word got %h expected 96", qi); end
  endtask

  task automatic test_d_inverted();
    logic [15:0] s = 16'h0FA5;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      send(s[i-1], 1'b1, 1'b0);
      if (i == 8) begin
        tests_run++; if (vd !== 1'b1 || qd !== 8'h5A) begin tests_failed++; $display("FAIL dinv_w0 got %b/%h expected 1/5a", vd, qd); end
      end
      if (i == 16) begin
        tests_run++; if (vd !== 1'b1 || qd !== 8'hF0) begin tests_failed++; $display("FAIL dinv_w1 got %b/%h expected 1/f0", vd, qd); end
      end
    end
  endtask

  task automatic test_clk_inverted();
    logic [15:0] s = 16'h3CA5;
    logic ev;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      // Data is valid only around the falling edge; the rising edge sees its complement.
      d = s[i-1]; ce = 1'b1; bitslip = 1'b0;
      @(negedge clk);
      #1;
      d = ~s[i-1];
      tick();
      ev = (i % 8 == 0);
      tests_run++; if (vc !== ev) begin tests_failed++; $display("FAIL clkinv_valid edge %0d got %b expected %b", i, vc, ev); end
      if (ev) begin
        tests_run++; if (qc !== ((i == 8) ? 8'hA5 : 8'h3C)) begin tests_failed++; $display("FAIL clkinv_q edge %0d got %h", i, qc); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; d = 1'b0; bitslip = 1'b0;
    test_reset();
    test_basic_w8();
    test_w4();
    test_bitslip();
    test_slip_at_boundary();
    test_ce_gating();
    test_reset_mid_word();
    test_d_inverted();
    test_clk_inverted();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
